// File: rtl/div_pkg.sv
// div_pkg: shared state type and BCD digit helpers for the BCD divider engine.
package div_pkg;
  typedef enum logic [2:0] {IDLE, CONV, DIV, B2D, FIN} div_state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/div_restoring.sv
// div_restoring: iterative restoring divider, one quotient bit per cycle, W cycles from start to done.
module div_restoring #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(W + 1);
  logic          run_q, run_d, active, ge;
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic [W-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, src_rem, src_quo;
  logic [W:0]    shf;
  // start performs the first step directly on the inputs so the divide takes exactly W cycles
  always_comb begin
    active  = start || run_q;
    idx     = start ? '0 : cnt_q;
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    dvs_d   = start ? divisor : dvs_q;
    shf     = {src_rem, src_quo[W-1]};
    ge      = shf >= {1'b0, dvs_d};
    done    = active && idx == CW'(W - 1);
    rem_d   = !active ? rem_q : ge ? W'(shf - {1'b0, dvs_d}) : shf[W-1:0];
    quo_d   = active ? {src_quo[W-2:0], ge} : quo_q;
    cnt_d   = active ? idx + 1'b1 : cnt_q;
    run_d   = active && !done;
  end
  assign quotient  = quo_d;
  assign remainder = rem_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
endmodule

// File: rtl/bcd_div_engine.sv
// bcd_div_engine: multi-cycle BCD-in/BCD-out unsigned divider (Horner conversion, restoring divide, double dabble).
module bcd_div_engine
  import div_pkg::*;
#(
  parameter int NDIG   = 3,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [4*NDIG-1:0] a_bcd,
  input  logic [4*NDIG-1:0] b_bcd,
  output logic [4*NDIG-1:0] q_bcd,
  output logic [4*NDIG-1:0] r_bcd,
  output logic              done,
  output logic              busy,
  output logic              div_by_zero,
  output logic              bcd_err
);
  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2((NDIG > DATA_W ? NDIG : DATA_W) + 1);

  if (2 ** DATA_W <= 10 ** NDIG - 1) begin : g_width_check
    $error("DATA_W too narrow to hold NDIG decimal digits");
  end

  div_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, a_hor, b_hor, quo, rem;
  logic [BW-1:0]     ad_q, ad_d, bd_q, bd_d, q_q, q_d, r_q, r_d, ad_dd, bd_dd;
  logic              dbz_q, dbz_d, err_q, err_d, bad, div_start, div_done;

  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] d, input logic bit_in);
    logic [BW-1:0] t;
    for (int i = 0; i < NDIG; i++)
      t[4*i +: 4] = d[4*i +: 4] >= 4'd5 ? d[4*i +: 4] + 4'd3 : d[4*i +: 4];
    return {t[BW-2:0], bit_in};
  endfunction

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      bad |= !bcd_digit_ok(a_bcd[4*i +: 4]) || !bcd_digit_ok(b_bcd[4*i +: 4]);
  end

  // a_q/b_q hold the binary operands, then quotient/remainder; ad_q/bd_q hold digits, then BCD results
  assign a_hor     = (a_q << 3) + (a_q << 1) + DATA_W'(ad_q[BW-1 -: 4]);
  assign b_hor     = (b_q << 3) + (b_q << 1) + DATA_W'(bd_q[BW-1 -: 4]);
  assign ad_dd     = dd_step(ad_q, a_q[DATA_W-1]);
  assign bd_dd     = dd_step(bd_q, b_q[DATA_W-1]);
  assign div_start = state_q == DIV && cnt_q == '0;

  div_restoring #(.W(DATA_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a_q),
    .divisor  (b_q),
    .done     (div_done),
    .quotient (quo),
    .remainder(rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ad_d    = ad_q;
    bd_d    = bd_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start_valid) begin
        state_d = bad ? FIN : CONV;
        {cnt_d, a_d, b_d} = '0;
        ad_d = a_bcd;
        bd_d = b_bcd;
        if (bad) {q_d, r_d, dbz_d, err_d} = {{(2*BW+1){1'b0}}, 1'b1};
      end
      CONV: begin
        a_d   = a_hor;
        b_d   = b_hor;
        ad_d  = ad_q << 4;
        bd_d  = bd_q << 4;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG - 1)) begin
          cnt_d   = '0;
          state_d = b_hor == '0 ? FIN : DIV;
          if (b_hor == '0) {q_d, r_d, dbz_d, err_d} = {{(2*BW){1'b0}}, 2'b10};
        end
      end
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (div_done) begin
          state_d = B2D;
          cnt_d   = '0;
          a_d     = quo;
          b_d     = rem;
          ad_d    = '0;
          bd_d    = '0;
        end
      end
      B2D: begin
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        ad_d  = ad_dd;
        bd_d  = bd_dd;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = FIN;
          {q_d, r_d, dbz_d, err_d} = {ad_dd, bd_dd, 2'b00};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ad_q    <= '0;
      bd_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ad_q    <= ad_d;
      bd_q    <= bd_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      err_q   <= err_d;
    end

  assign start_ready = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign done        = state_q == FIN;
  assign q_bcd       = q_q;
  assign r_bcd       = r_q;
  assign div_by_zero = dbz_q;
  assign bcd_err     = err_q;
endmodule

// File: tb/tb_bcd_div_engine.sv
// tb_bcd_div_engine: directed and random checks of the BCD divider against an arithmetic reference model.
module tb_bcd_div_engine;
  localparam int ND = 3;
  localparam int DW = 10;

  logic clk = 1'b0, rst_n = 1'b0, start_valid = 1'b0;
  logic [11:0] a_bcd = '0, b_bcd = '0;
  logic start_ready, done, busy, div_by_zero, bcd_err;
  logic [11:0] q_bcd, r_bcd;
  int checks = 0, errors = 0;

  bcd_div_engine #(.NDIG(ND), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a_bcd(a_bcd), .b_bcd(b_bcd), .q_bcd(q_bcd), .r_bcd(r_bcd), .done(done),
    .busy(busy), .div_by_zero(div_by_zero), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [11:0] x);
    int s = 0;
    for (int i = 2; i >= 0; i--) begin
      if (x[4*i +: 4] > 4'd9) return -1;
      s = s * 10 + int'(x[4*i +: 4]);
    end
    return s;
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int ref_lat(input logic [11:0] a, input logic [11:0] b);
    if (bcd2int(a) < 0 || bcd2int(b) < 0) return 1;
    if (bcd2int(b) == 0) return ND + 1;
    return ND + 2 * DW + 1;
  endfunction

  // Reference: latency schedule plus plain integer division of the decoded operands
  logic m_active, m_done, m_dbz, m_err, p_dbz, p_err;
  logic [11:0] m_q, m_r, p_q, p_r;
  int m_k, m_lat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_k <= 0; m_lat <= 0;
      m_q <= '0; m_r <= '0; m_dbz <= 1'b0; m_err <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_k == m_lat) m_active <= 1'b0;
        else begin
          m_k <= m_k + 1;
          if (m_k + 1 == m_lat) begin
            m_q <= p_q; m_r <= p_r; m_dbz <= p_dbz; m_err <= p_err; m_done <= 1'b1;
          end
        end
      end else if (start_valid) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_lat    <= ref_lat(a_bcd, b_bcd);
        p_err    <= ref_lat(a_bcd, b_bcd) == 1;
        p_dbz    <= ref_lat(a_bcd, b_bcd) == ND + 1;
        p_q      <= ref_lat(a_bcd, b_bcd) == ND + 2 * DW + 1 ? int2bcd(bcd2int(a_bcd) / bcd2int(b_bcd)) : 12'h000;
        p_r      <= ref_lat(a_bcd, b_bcd) == ND + 2 * DW + 1 ? int2bcd(bcd2int(a_bcd) % bcd2int(b_bcd)) : 12'h000;
        if (ref_lat(a_bcd, b_bcd) == 1) begin
          m_q <= '0; m_r <= '0; m_dbz <= 1'b0; m_err <= 1'b1; m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("done", done, m_done);
    chk("busy", busy, m_active);
    chk("start_ready", start_ready, !m_active);
    chk("q_bcd", q_bcd, m_q);
    chk("r_bcd", r_bcd, m_r);
    chk("div_by_zero", div_by_zero, m_dbz);
    chk("bcd_err", bcd_err, m_err);
  end

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [11:0] a, input logic [11:0] b, input int lat,
                       input logic [11:0] eq, input logic [11:0] er, input logic edbz, input logic eerr);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!start_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    start_valid = 1'b1; a_bcd = a; b_bcd = b;
    @(posedge clk); #1;
    start_valid = 1'b0;
    wait_done(n);
    chk("op_latency", n, lat);
    chk("op_q", q_bcd, eq);
    chk("op_r", r_bcd, er);
    chk("op_dbz", div_by_zero, edbz);
    chk("op_err", bcd_err, eerr);
  endtask

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    for (int i = 0; i < 3; i++)
      v[4*i +: 4] = $urandom_range(0, 30) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    int n, seen;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("reset_ready", start_ready, 1);
    chk("reset_q", q_bcd, 0);
    chk("reset_busy", busy, 0);

    do_op(12'h100, 12'h007, 24, 12'h014, 12'h002, 1'b0, 1'b0);
    do_op(12'h123, 12'h000, 4, 12'h000, 12'h000, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("dbz_ready_next", start_ready, 1);
    do_op(12'h1A3, 12'h002, 1, 12'h000, 12'h000, 1'b0, 1'b1);

    // back-to-back with start_valid held
    @(posedge clk); #1;
    start_valid = 1'b1; a_bcd = 12'h999; b_bcd = 12'h001;
    @(posedge clk); #1;
    a_bcd = 12'h005; b_bcd = 12'h009;
    wait_done(n);
    chk("b2b_lat1", n, 24);
    chk("b2b_q1", q_bcd, 12'h999);
    chk("b2b_r1", r_bcd, 12'h000);
    @(posedge clk); #1;
    chk("b2b_ready_after_done", start_ready, 1);
    @(posedge clk); #1;
    chk("b2b_second_accept", busy, 1);
    start_valid = 1'b0;
    wait_done(n);
    chk("b2b_lat2", n, 24);
    chk("b2b_q2", q_bcd, 12'h000);
    chk("b2b_r2", r_bcd, 12'h005);

    // requests while busy are ignored
    @(posedge clk); #1;
    start_valid = 1'b1; a_bcd = 12'h500; b_bcd = 12'h003;
    @(posedge clk); #1;
    n = 1;
    while (!done && n < 100) begin
      start_valid = n == 5 || n == 10;
      a_bcd = start_valid ? 12'h777 : 12'h500;
      b_bcd = start_valid ? 12'h002 : 12'h003;
      @(posedge clk); #1;
      n++;
    end
    start_valid = 1'b0;
    chk("ignore_lat", n, 24);
    chk("ignore_q", q_bcd, 12'h166);
    chk("ignore_r", r_bcd, 12'h002);

    // reset mid-operation
    @(posedge clk); #1;
    start_valid = 1'b1; a_bcd = 12'h500; b_bcd = 12'h003;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q", q_bcd, 0);
    chk("rst_r", r_bcd, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", start_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("rst_no_done", seen, 0);
    do_op(12'h050, 12'h007, 24, 12'h007, 12'h001, 1'b0, 1'b0);

    // random traffic, including requests while busy, zero divisors and bad digits
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      start_valid = $urandom_range(0, 3) == 0;
      a_bcd = rand_bcd();
      b_bcd = $urandom_range(0, 9) == 0 ? 12'h000 : rand_bcd();
      if ($urandom_range(0, 3) == 0) b_bcd = {8'h00, 4'($urandom_range(1, 9))};
    end
    start_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_div_engine.md
Name: bcd_div_engine

Overview:
Parametrised BCD-in/BCD-out unsigned divider core for the keypad calculator datapath. It sits between the operand-entry FSM and the display mux.
- Accepts two NDIG-digit BCD operands through a valid/ready handshake.
- Converts both operands to binary, then runs a restoring division.
- Converts quotient and remainder back to BCD.
- Flags divide-by-zero and illegal BCD digits.
- Replaces the fixed 7-bit divider and the separate converter instances with one multi-cycle engine.

Parameters:
NDIG, 3, number of BCD digits per operand and per result (quotient and remainder).
DATA_W, 10, internal binary width; must satisfy 2**DATA_W > 10**NDIG - 1. An elaboration-time assertion enforces this.

Ports:
clk  input  1  system clock (27 MHz)
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operands presented and request to divide
start_ready  output  1  engine idle; can accept a request
a_bcd  input  4*NDIG  dividend, packed BCD, MS digit at MSBs
b_bcd  input  4*NDIG  divisor, packed BCD, MS digit at MSBs
q_bcd  output  4*NDIG  quotient, packed BCD
r_bcd  output  4*NDIG  remainder, packed BCD
done  output  1  one-cycle pulse; results and flags updated this cycle
busy  output  1  high from accept until the done cycle inclusive
div_by_zero  output  1  last operation had a zero divisor
bcd_err  output  1  last operation had a digit > 9 in a_bcd or b_bcd

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - q_bcd=0, r_bcd=0, done=0, busy=0, div_by_zero=0, bcd_err=0, start_ready=1.
  - Reset mid-operation abandons the operation; no done pulse is produced.
- Handshake:
  - start_ready = (state==IDLE).
  - Accept occurs on a rising edge with start_valid && start_ready; a_bcd/b_bcd are captured into internal registers on that edge.
  - start_valid while busy is ignored; no queuing.
- FSM states: IDLE, CONV, DIV, B2D, FIN.
  - IDLE: on accept, if any digit of either operand > 9, go to FIN with err=bcd; else go to CONV with digit counter=0 and accumulators=0.
  - CONV: NDIG cycles, one digit per cycle MS first, both operands in parallel: acc <= acc*10 + digit (acc*10 computed as (acc<<3)+(acc<<1), DATA_W bits). After the last digit: if B==0, go to FIN with err=dbz; else go to DIV.
  - DIV: DATA_W cycles of restoring division, MSB first.
    - Partial remainder is DATA_W+1 bits.
    - Each cycle: shift in the next dividend bit, trial-subtract B, and on non-negative result keep it and set the quotient bit to 1.
  - B2D: DATA_W cycles of shift-add-3 (double dabble) on Q and R in parallel; each BCD digit >= 5 gets +3 before each shift.
  - FIN: one cycle.
    - done=1.
    - q_bcd/r_bcd are loaded from the converters; on any error they are loaded with 0.
    - div_by_zero/bcd_err are loaded with this operation's flags; both are never set together, and bcd_err wins.
    - Next state is IDLE.
- Latency, counting accept edge = cycle 0, done high in cycle:
  - Normal: NDIG + 2*DATA_W + 1 (defaults: 24).
  - Divide-by-zero: NDIG + 1 (defaults: 4).
  - BCD error: 1.
- busy = (state != IDLE).
- Outputs and flags hold their values between done pulses. done never stays high for two consecutive cycles.
- A new accept is possible in the cycle after done (back-to-back throughput = latency + 1).
- Arithmetic is unsigned throughout; results always fit in NDIG digits because Q <= A and R < B.

Decomposition:
- Shared package div_pkg:
  - div_state_t enum (IDLE, CONV, DIV, B2D, FIN).
  - localparam BCD_MAX = 4'd9.
  - Function bcd_digit_ok(logic [3:0]).
- One sub-module: div_restoring #(.W(DATA_W)), the iterative restoring divider.
  - Interface: start/done handshake, dividend, divisor, quotient, remainder.
  - Instantiated once; the top FSM sequences it.
- Horner conversion and double dabble stay inline.

Test Plan:
- a=100, b=007, then sample -> done exactly at cycle 24; q_bcd=12'h014, r_bcd=12'h002; both flags 0.
- a=999, b=001 then a=005, b=009 back-to-back, start_valid held -> first done q=999, r=000; second accept in the cycle after done; second done q=000, r=005.
- a=123, b=000 -> done at cycle 4; div_by_zero=1, bcd_err=0, q=r=000; start_ready=1 in the next cycle.
- a=12'h1A3, b=002 -> done at cycle 1; bcd_err=1, q=r=000.
- Accept a=500, b=003, then pulse start_valid with new operands at cycles 5 and 10 -> ignored; done at 24 with q=166, r=002.
- Accept a=500, b=003, drop rst_n at cycle 10 -> all outputs 0 immediately; no done pulse; next request a=050, b=007 -> q=007, r=001.
